mcycle_control_fsm: RTL

Multi-cycle control unit for the 16-bit TSC datapath. It replaces the single-cycle combinational decoder with a state machine that sequences each instruction through fetch, decode, execute, memory and write-back. Memory accesses are stretched by a ready handshake, and the unit counts retired instructions. It sits between the instruction register, ALU branch-condition output, unified memory port and register file / PC write-enables.

---
 rtl/tsc_pkg.sv | 54 +++++
 rtl/tsc_inst_class.sv | 35 +++
 rtl/mcycle_control_fsm.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tsc_pkg.sv
// Shared encodings for the multi-cycle TSC control unit: opcodes, funcodes,
// FSM states, mux-select encodings and the decoded instruction-class flags.
package tsc_pkg;

   localparam logic [3:0] OP_BRANCH_MAX = 4'd3;
   localparam logic [3:0] OP_IALU_MIN   = 4'd4;
   localparam logic [3:0] OP_IALU_MAX   = 4'd6;
   localparam logic [3:0] OP_LWD        = 4'd7;
   localparam logic [3:0] OP_SWD        = 4'd8;
   localparam logic [3:0] OP_JMP        = 4'd9;
   localparam logic [3:0] OP_JAL        = 4'd10;
   localparam logic [3:0] OP_RTYPE      = 4'd15;

   localparam logic [5:0] FN_ALU_MAX = 6'd7;
   localparam logic [5:0] FN_JPR     = 6'd25;
   localparam logic [5:0] FN_JRL     = 6'd26;
   localparam logic [5:0] FN_WWD     = 6'd28;
   localparam logic [5:0] FN_HLT     = 6'd29;

   localparam logic [2:0] S_IF   = 3'd0;
   localparam logic [2:0] S_ID   = 3'd1;
   localparam logic [2:0] S_EX   = 3'd2;
   localparam logic [2:0] S_MEM  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_HALT = 3'd5;

   localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_RS     = 2'd3;

   localparam logic [1:0] WDC_ALU = 2'd0;
   localparam logic [1:0] WDC_MEM = 2'd1;
   localparam logic [1:0] WDC_PC1 = 2'd2;

   localparam logic [1:0] WRC_RT = 2'd0;
   localparam logic [1:0] WRC_RD = 2'd1;
   localparam logic [1:0] WRC_R2 = 2'd2;

   typedef struct packed {
      logic is_branch;
      logic is_ialu;
      logic is_lwd;
      logic is_swd;
      logic is_jmp;
      logic is_jal;
      logic is_rtype_alu;
      logic is_jpr;
      logic is_jrl;
      logic is_wwd;
      logic is_hlt;
   } inst_class_t;

endpackage

// File: rtl/tsc_inst_class.sv
// Combinational decode of the IR into one-hot class flags; no latency, no handshake.
// An encoding matching no class leaves every flag low and is treated as a NOP.
module tsc_inst_class
   import tsc_pkg::*;
#(
   parameter int WORD_SIZE = 16
) (
   input  logic [WORD_SIZE-1:0] inst_i,
   output inst_class_t          cls_o
);

   logic [3:0] op;
   logic [5:0] fn;
   logic       unused_mid;

   assign op         = inst_i[WORD_SIZE-1 -: 4];
   assign fn         = inst_i[5:0];
   assign unused_mid = ^inst_i[WORD_SIZE-5:6];

   always_comb begin
      cls_o              = '0;
      cls_o.is_branch    = (op <= OP_BRANCH_MAX);
      cls_o.is_ialu      = (op >= OP_IALU_MIN) && (op <= OP_IALU_MAX);
      cls_o.is_lwd       = (op == OP_LWD);
      cls_o.is_swd       = (op == OP_SWD);
      cls_o.is_jmp       = (op == OP_JMP);
      cls_o.is_jal       = (op == OP_JAL);
      cls_o.is_rtype_alu = (op == OP_RTYPE) && (fn <= FN_ALU_MAX);
      cls_o.is_jpr       = (op == OP_RTYPE) && (fn == FN_JPR);
      cls_o.is_jrl       = (op == OP_RTYPE) && (fn == FN_JRL);
      cls_o.is_wwd       = (op == OP_RTYPE) && (fn == FN_WWD);
      cls_o.is_hlt       = (op == OP_RTYPE) && (fn == FN_HLT);
   end

endmodule

// File: rtl/mcycle_control_fsm.sv
// Multi-cycle TSC control: IF/ID/EX/MEM/WB sequencing, 2-5 cycles per instruction
// at zero wait; IF and MEM stall while mem_ready is low. Counts retired instructions.
module mcycle_control_fsm
   import tsc_pkg::*;
#(
   parameter int WORD_SIZE  = 16,
   parameter int NUM_INST_W = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [WORD_SIZE-1:0]  inst,
   input  logic                  mem_ready,
   input  logic                  bcond,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  i_or_d,
   output logic                  ir_write,
   output logic                  reg_write,
   output logic [1:0]            write_data_ctrl,
   output logic [1:0]            write_reg_ctrl,
   output logic                  alu_src,
   output logic                  pc_write,
   output logic [1:0]            pc_src,
   output logic                  output_valid,
   output logic                  is_halted,
   output logic [NUM_INST_W-1:0] num_inst
);

   inst_class_t           cls;
   logic [2:0]            state_q, state_d;
   logic [NUM_INST_W-1:0] num_inst_q, num_inst_d;
   logic                  retire;
   logic                  multi_cycle;

   tsc_inst_class #(.WORD_SIZE(WORD_SIZE)) u_class (
      .inst_i (inst),
      .cls_o  (cls)
   );

   assign multi_cycle = cls.is_branch | cls.is_ialu | cls.is_lwd | cls.is_swd | cls.is_rtype_alu;

   always_comb begin
      state_d         = state_q;
      retire          = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      i_or_d          = 1'b0;
      ir_write        = 1'b0;
      reg_write       = 1'b0;
      write_data_ctrl = WDC_ALU;
      write_reg_ctrl  = WRC_RT;
      alu_src         = 1'b0;
      pc_write        = 1'b0;
      pc_src          = PC_SRC_SEQ;
      output_valid    = 1'b0;
      is_halted       = 1'b0;

      case (state_q)
         S_IF: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               state_d  = S_ID;
            end
         end
         S_ID: begin
            if (cls.is_hlt) begin
               state_d = S_HALT;
            end else if (multi_cycle) begin
               state_d = S_EX;
            end else begin
               // Jumps, links, WWD and NOPs all finish here.
               pc_write = 1'b1;
               retire   = 1'b1;
               if (cls.is_jmp || cls.is_jal) pc_src = PC_SRC_JUMP;
               if (cls.is_jpr || cls.is_jrl) pc_src = PC_SRC_RS;
               if (cls.is_jal || cls.is_jrl) begin
                  reg_write       = 1'b1;
                  write_reg_ctrl  = WRC_R2;
                  write_data_ctrl = WDC_PC1;
               end
               output_valid = cls.is_wwd;
            end
         end
         S_EX: begin
            alu_src = cls.is_ialu | cls.is_lwd | cls.is_swd;
            if (cls.is_branch) begin
               pc_write = 1'b1;
               pc_src   = bcond ? PC_SRC_BRANCH : PC_SRC_SEQ;
               retire   = 1'b1;
            end else if (cls.is_ialu || cls.is_rtype_alu) begin
               state_d = S_WB;
            end else if (cls.is_lwd || cls.is_swd) begin
               state_d = S_MEM;
            end else begin
               state_d = S_IF;
            end
         end
         S_MEM: begin
            i_or_d    = 1'b1;
            mem_read  = cls.is_lwd;
            mem_write = cls.is_swd;
            if (mem_ready) begin
               if (cls.is_lwd) begin
                  state_d = S_WB;
               end else begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
               end
            end
         end
         S_WB: begin
            reg_write       = 1'b1;
            write_reg_ctrl  = cls.is_rtype_alu ? WRC_RD : WRC_RT;
            write_data_ctrl = cls.is_lwd ? WDC_MEM : WDC_ALU;
            pc_write        = 1'b1;
            retire          = 1'b1;
         end
         S_HALT: begin
            is_halted = 1'b1;
         end
         default: begin
            state_d = S_IF;
         end
      endcase

      if (retire) state_d = S_IF;
   end

   // HLT is counted on its way into the halt state; nothing counts after that.
   always_comb begin
      num_inst_d = num_inst_q;
      if (retire || (state_q == S_ID && cls.is_hlt))
         num_inst_d = num_inst_q + NUM_INST_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IF;
         num_inst_q <= '0;
      end else begin
         state_q    <= state_d;
         num_inst_q <= num_inst_d;
      end
   end

   assign num_inst = num_inst_q;

endmodule
